seg7_letter_sequencer: RTL and testbench

- Upstream stage that drives the 4-bit `digit` input of the seg7 letter decoder.
- Steps through letter codes 0..LAST_CODE (A,B,C,D,E,F) at a prescaled rate, or one code per single-step press.
- Also provides a blank output using code 4'hF, which the decoder maps to all segments off.
- Sits between the top-level pin/enable logic and the decoder. Its `digit` output connects directly to the decoder input.

---
 rtl/seg7_pkg.sv | 18 +
 rtl/sync_edge.sv | 40 ++++
 rtl/seg7_letter_sequencer.sv | 124 ++++++++++++
 tb/tb_seg7_letter_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and code constants for the seg7 letter decoder and its sequencer.
package seg7_pkg;

  typedef enum logic [1:0] {
    BLANK = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [3:0] CODE_BLANK = 4'hF;
  localparam logic [3:0] CODE_A     = 4'd0;
  localparam logic [3:0] CODE_B     = 4'd1;
  localparam logic [3:0] CODE_C     = 4'd2;
  localparam logic [3:0] CODE_D     = 4'd3;
  localparam logic [3:0] CODE_E     = 4'd4;
  localparam logic [3:0] CODE_F     = 4'd5;

endpackage

// File: rtl/sync_edge.sv
// Two-flop pin synchroniser with an optional third flop for rising-edge detection.
module sync_edge #(
  parameter bit RISE_EN = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic d,
  output logic q,
  output logic rise
);

  logic s1, s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else if (ena) begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign q = s2;

  generate
    if (RISE_EN) begin : g_rise
      logic s3;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   s3 <= '0;
        else if (ena) s3 <= s2;
      end
      assign rise = s2 & ~s3;
    end else begin : g_no_rise
      assign rise = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/seg7_letter_sequencer.sv
// Steps the decoder's letter code 0..LAST_CODE automatically or per step press, with a blank state.
module seg7_letter_sequencer
  import seg7_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 12_000_000,
  parameter int unsigned CNT_W     = 24,
  parameter int unsigned LAST_CODE = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       clr,
  input  logic       run,
  input  logic       dir,
  input  logic       step,
  output logic [3:0] digit,
  output logic       active,
  output logic       wrap
);

  localparam logic [3:0]       LAST = 4'(LAST_CODE);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_DIV - 1);

  logic clr_s, run_s, dir_s, step_s, step_rise;
  logic clr_rise_unused, run_rise_unused, dir_rise_unused, step_s_unused;

  sync_edge #(.RISE_EN(1'b0)) u_clr  (.clk(clk), .rst_n(rst_n), .ena(ena), .d(clr),  .q(clr_s),  .rise(clr_rise_unused));
  sync_edge #(.RISE_EN(1'b0)) u_run  (.clk(clk), .rst_n(rst_n), .ena(ena), .d(run),  .q(run_s),  .rise(run_rise_unused));
  sync_edge #(.RISE_EN(1'b0)) u_dir  (.clk(clk), .rst_n(rst_n), .ena(ena), .d(dir),  .q(dir_s),  .rise(dir_rise_unused));
  sync_edge #(.RISE_EN(1'b1)) u_step (.clk(clk), .rst_n(rst_n), .ena(ena), .d(step), .q(step_s), .rise(step_rise));

  assign step_s_unused = step_s;

  state_t           state, state_n;
  logic [3:0]       code, code_n, adv_code;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             wrap_q, wrap_n, adv_wrap, do_adv;

  always_comb begin
    if (dir_s) begin
      adv_wrap = (code == 4'd0);
      adv_code = adv_wrap ? LAST : code - 4'd1;
    end else begin
      adv_wrap = (code == LAST);
      adv_code = adv_wrap ? 4'd0 : code + 4'd1;
    end
  end

  always_comb begin
    state_n = state;
    code_n  = code;
    cnt_n   = cnt;
    wrap_n  = 1'b0;
    do_adv  = 1'b0;
    if (clr_s) begin
      state_n = BLANK;
      code_n  = CODE_BLANK;
      cnt_n   = '0;
    end else begin
      unique case (state)
        BLANK: begin
          if (run_s) begin
            state_n = RUN;
            code_n  = CODE_A;
            cnt_n   = '0;
          end else if (step_rise) begin
            state_n = PAUSE;
            code_n  = CODE_A;
          end
        end
        RUN: begin
          // Dropping run wins over a coincident terminal count: no advance.
          if (!run_s) begin
            state_n = PAUSE;
            cnt_n   = '0;
          end else if (cnt == TERM) begin
            cnt_n  = '0;
            do_adv = 1'b1;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        PAUSE: begin
          if (run_s) begin
            state_n = RUN;
            cnt_n   = '0;
          end else if (step_rise) begin
            do_adv = 1'b1;
          end
        end
        default: begin
          state_n = BLANK;
          code_n  = CODE_BLANK;
          cnt_n   = '0;
        end
      endcase
      if (do_adv) begin
        code_n = adv_code;
        wrap_n = adv_wrap;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= BLANK;
      code   <= CODE_BLANK;
      cnt    <= '0;
      wrap_q <= 1'b0;
    end else if (ena) begin
      state  <= state_n;
      code   <= code_n;
      cnt    <= cnt_n;
      wrap_q <= wrap_n;
    end else begin
      wrap_q <= 1'b0;
    end
  end

  assign digit  = code;
  assign active = (state == RUN) || (state == PAUSE);
  assign wrap   = wrap_q & ena;

endmodule

// File: tb/tb_seg7_letter_sequencer.sv
// Self-checking bench: directed scenarios with literal expectations plus a randomized run
// compared every cycle against a behavioural model of the sequencer.
module tb_seg7_letter_sequencer;

  localparam int TDIV = 4;
  localparam int LAST = 5;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena   = 1'b1;
  logic       clr   = 1'b0;
  logic       run   = 1'b0;
  logic       dir   = 1'b0;
  logic       step  = 1'b0;
  logic [3:0] digit;
  logic       active;
  logic       wrap;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  seg7_letter_sequencer #(.TICK_DIV(TDIV), .CNT_W(3), .LAST_CODE(LAST)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .clr(clr), .run(run), .dir(dir),
    .step(step), .digit(digit), .active(active), .wrap(wrap)
  );

  always #5 clk = ~clk;

  // Model: mode 0=blank 1=auto-run 2=paused. Pins are seen by the control
  // logic two enabled edges after they are sampled; history is {clr,run,dir,step}.
  int         m_mode  = 0;
  int         m_digit = 15;
  int         m_ticks = 0;
  bit         m_wrap  = 1'b0;
  logic [3:0] h[3]    = '{4'b0, 4'b0, 4'b0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_digit = 15; m_ticks = 0; m_wrap = 1'b0;
      h = '{4'b0, 4'b0, 4'b0};
    end else if (!ena) begin
      m_wrap = 1'b0;
    end else begin
      bit e_clr, e_run, e_dir, e_rise, adv;
      e_clr  = h[1][3];
      e_run  = h[1][2];
      e_dir  = h[1][1];
      e_rise = h[1][0] && !h[2][0];
      adv    = 1'b0;
      m_wrap = 1'b0;
      if (e_clr) begin
        m_mode = 0; m_digit = 15; m_ticks = 0;
      end else if (m_mode == 0) begin
        if (e_run)       begin m_mode = 1; m_digit = 0; m_ticks = 0; end
        else if (e_rise) begin m_mode = 2; m_digit = 0; end
      end else if (m_mode == 1) begin
        if (!e_run) begin
          m_mode = 2; m_ticks = 0;
        end else begin
          m_ticks++;
          if (m_ticks == TDIV) begin m_ticks = 0; adv = 1'b1; end
        end
      end else begin
        if (e_run)       begin m_mode = 1; m_ticks = 0; end
        else if (e_rise) adv = 1'b1;
      end
      if (adv) begin
        if (e_dir) begin
          m_wrap  = (m_digit == 0);
          m_digit = (m_digit + LAST) % (LAST + 1);
        end else begin
          m_wrap  = (m_digit == LAST);
          m_digit = (m_digit + 1) % (LAST + 1);
        end
      end
      h[2] = h[1];
      h[1] = h[0];
      h[0] = {clr, run, dir, step};
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [3:0] e_dig;
      logic       e_act, e_wrp;
      e_dig = 4'(m_digit);
      e_act = (m_mode != 0);
      e_wrp = m_wrap && ena;
      tests++;
      if (digit !== e_dig || active !== e_act || wrap !== e_wrp) begin
        fails++;
        $display("FAIL model_cmp t=%0t digit=%h exp=%h active=%b exp=%b wrap=%b exp=%b",
                 $time, digit, e_dig, active, e_act, wrap, e_wrp);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    cyc(3);
    rst_n = 1'b1;
    check("reset_digit", digit, 15);
    check("reset_active", active, 0);
    check("reset_wrap", wrap, 0);
    cyc(20);
    check("idle_digit", digit, 15);
    check("idle_active", active, 0);

    // Auto-run upward through a full wrap.
    run = 1'b1;
    cyc(3);
    check("run_entry_digit", digit, 0);
    check("run_entry_active", active, 1);
    for (int i = 1; i <= 6; i++) begin
      cyc(4);
      check("run_up_digit", digit, i % 6);
      check("run_up_wrap", wrap, (i == 6) ? 1 : 0);
    end
    cyc(1);
    check("wrap_one_cycle", wrap, 0);

    // Pause at 0, then single steps downward.
    run = 1'b0; dir = 1'b1;
    cyc(3);
    check("pause_digit", digit, 0);
    step = 1'b1;
    cyc(3);
    check("step_down_digit", digit, 5);
    check("step_down_wrap", wrap, 1);
    cyc(2);
    step = 1'b0;
    check("step_single_digit", digit, 5);
    check("step_single_wrap", wrap, 0);
    cyc(3);
    step = 1'b1;
    cyc(10);
    check("step_held_digit", digit, 4);
    step = 1'b0;
    cyc(4);

    // run_s falls exactly on a terminal-count cycle.
    dir = 1'b0; run = 1'b1;
    cyc(3);
    check("rerun_digit", digit, 4);
    cyc(1);
    run = 1'b0;
    cyc(3);
    check("tc_drop_digit", digit, 4);
    check("tc_drop_active", active, 1);
    run = 1'b1;
    cyc(3);
    cyc(3);
    check("reentry_hold", digit, 4);
    cyc(1);
    check("reentry_adv", digit, 5);

    // clr beats a simultaneous step rise in PAUSE.
    run = 1'b0;
    cyc(3);
    check("pause2_digit", digit, 5);
    clr = 1'b1; step = 1'b1;
    cyc(3);
    check("clr_digit", digit, 15);
    check("clr_active", active, 0);
    clr = 1'b0; step = 1'b0;
    cyc(4);

    // Asynchronous reset mid-RUN.
    run = 1'b1;
    cyc(8);
    check("pre_rst_digit", digit, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_digit", digit, 15);
    check("async_rst_active", active, 0);
    run = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(3);

    // ena low mid-count with prescaler at 2.
    run = 1'b1;
    cyc(3);
    cyc(2);
    ena = 1'b0;
    cyc(7);
    check("frozen_digit", digit, 0);
    ena = 1'b1;
    cyc(1);
    check("resume_hold", digit, 0);
    cyc(1);
    check("resume_adv", digit, 1);

    // Randomized phase against the model.
    for (int i = 0; i < 3000; i++) begin
      cyc(1);
      if ($urandom_range(19) == 0) run  = ~run;
      if ($urandom_range(7)  == 0) dir  = ~dir;
      if ($urandom_range(3)  == 0) step = ~step;
      clr = ($urandom_range(79) == 0);
      ena = ($urandom_range(9) != 0);
    end
    ena = 1'b1;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
